// File: rtl/reg_32_pkg.sv
// Shared widths, memory latency and FSM state encoding for the reg_32 cache.
package reg_32_pkg;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int TAG_W     = 2;
  localparam int INDEX_W   = 2;
  localparam int MEM_LAT   = 2;
  localparam int LINES     = 1 << INDEX_W;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int CNT_W     = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    WRITE_BACK  = 2'd2,
    ALLOCATE    = 2'd3
  } state_t;
endpackage

// File: rtl/reg_32_mem.sv
// Backing store: 16x8 array initialised to {a, ~a} on reset, with a fixed-latency access counter.
module reg_32_mem
  import reg_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [CNT_W-1:0]  cnt;

  // done pulses in the last cycle of each MEM_LAT-cycle access window
  assign done  = busy && (cnt == CNT_W'(MEM_LAT - 1));
  assign rdata = mem[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!busy || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < MEM_DEPTH; a++) begin
        mem[a] <= {ADDR_W'(a), ~ADDR_W'(a)};
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/reg_32.sv
// Direct-mapped, write-back/write-allocate cache of four 1-byte lines in front of reg_32_mem.
module reg_32
  import reg_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_datain,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic [DATA_W-1:0] cpu_req_dataout,
  output logic              cache_ready
);

  state_t state, next_state;

  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_data;
  logic               req_rw;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;

  logic [LINES-1:0]   line_valid;
  logic [LINES-1:0]   line_dirty;
  logic [TAG_W-1:0]   line_tag  [LINES];
  logic [DATA_W-1:0]  line_data [LINES];

  logic               hit;
  logic               victim_dirty;
  logic               mem_busy;
  logic               mem_we;
  logic               mem_done;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_rdata;

  assign req_tag      = req_addr[ADDR_W-1:INDEX_W];
  assign req_index    = req_addr[INDEX_W-1:0];
  assign hit          = line_valid[req_index] && (line_tag[req_index] == req_tag);
  assign victim_dirty = line_valid[req_index] && line_dirty[req_index];
  assign cache_ready  = (state == IDLE);

  // During write-back the memory address is the victim's, otherwise the request's
  assign mem_busy = (state == WRITE_BACK) || (state == ALLOCATE);
  assign mem_we   = (state == WRITE_BACK) && mem_done;
  assign mem_addr = (state == WRITE_BACK) ? {line_tag[req_index], req_index} : req_addr;

  reg_32_mem u_mem (
    .clk   (clk),
    .rst   (rst_n),
    .busy  (mem_busy),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (line_data[req_index]),
    .rdata (mem_rdata),
    .done  (mem_done)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (cpu_req_valid) next_state = COMPARE_TAG;
      COMPARE_TAG: begin
        if (hit)               next_state = IDLE;
        else if (victim_dirty) next_state = WRITE_BACK;
        else                   next_state = ALLOCATE;
      end
      WRITE_BACK:  if (mem_done) next_state = ALLOCATE;
      ALLOCATE:    if (mem_done) next_state = COMPARE_TAG;
      default:     next_state = IDLE;
    endcase
  end

  // Line fill only happens on the final ALLOCATE edge, so a reset mid-access leaves no partial line
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      req_addr        <= '0;
      req_data        <= '0;
      req_rw          <= 1'b0;
      cpu_req_dataout <= '0;
      line_valid      <= '0;
      line_dirty      <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_addr <= cpu_req_addr;
            req_data <= cpu_req_datain;
            req_rw   <= cpu_req_rw;
          end
        end
        COMPARE_TAG: begin
          if (hit) begin
            if (req_rw) begin
              line_data[req_index]  <= req_data;
              line_dirty[req_index] <= 1'b1;
            end else begin
              cpu_req_dataout <= line_data[req_index];
            end
          end
        end
        ALLOCATE: begin
          if (mem_done) begin
            line_data[req_index]  <= mem_rdata;
            line_tag[req_index]   <= req_tag;
            line_valid[req_index] <= 1'b1;
            line_dirty[req_index] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_32.sv
// Directed table-driven bench for reg_32: checks latency (cache_ready low cycles) and read data.
module tb_reg_32;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cpu_req_addr = '0;
  logic [7:0] cpu_req_datain = '0;
  logic       cpu_req_rw = 1'b0;
  logic       cpu_req_valid = 1'b0;
  logic [7:0] cpu_req_dataout;
  logic       cache_ready;

  int tests = 0;
  int fails = 0;

  reg_32 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_datain  (cpu_req_datain),
    .cpu_req_rw      (cpu_req_rw),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_dataout (cpu_req_dataout),
    .cache_ready     (cache_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       rw;
    int         lat;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called just after a falling edge with the cache idle; returns at the falling edge where it is idle again
  task automatic run_req(input logic [3:0] addr, input logic [7:0] data, input logic rw, output int lat);
    cpu_req_addr   = addr;
    cpu_req_datain = data;
    cpu_req_rw     = rw;
    cpu_req_valid  = 1'b1;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (cache_ready == 1'b0 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;

    vecs[0]  = '{4'hA, 8'h00, 1'b0, 4, 8'hA5};
    vecs[1]  = '{4'hA, 8'h00, 1'b0, 1, 8'hA5};
    vecs[2]  = '{4'hB, 8'hC0, 1'b1, 4, 8'hA5};
    vecs[3]  = '{4'hB, 8'h00, 1'b0, 1, 8'hC0};
    vecs[4]  = '{4'h3, 8'h00, 1'b0, 6, 8'h3C};
    vecs[5]  = '{4'hB, 8'h00, 1'b0, 4, 8'hC0};
    vecs[6]  = '{4'h3, 8'h55, 1'b1, 4, 8'hC0};
    vecs[7]  = '{4'h7, 8'h00, 1'b0, 6, 8'h78};
    vecs[8]  = '{4'h3, 8'h00, 1'b0, 4, 8'h55};
    vecs[9]  = '{4'h0, 8'h00, 1'b0, 4, 8'h0F};
    vecs[10] = '{4'h0, 8'h00, 1'b0, 1, 8'h0F};
    vecs[11] = '{4'h0, 8'h99, 1'b1, 1, 8'h0F};
    vecs[12] = '{4'h2, 8'h00, 1'b0, 4, 8'h2D};

    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(cache_ready), 1);
    check("reset_dout", int'(cpu_req_dataout), 8'h00);

    foreach (vecs[i]) begin
      run_req(vecs[i].addr, vecs[i].data, vecs[i].rw, lat);
      $display("[TB] %s addr=0x%0h data=0x%0h lat=%0d dout=0x%0h",
               vecs[i].rw ? "WR" : "RD", vecs[i].addr, vecs[i].data, lat, cpu_req_dataout);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_dout", i), int'(cpu_req_dataout), int'(vecs[i].dout));
    end

    // Line 2 now holds 0x2, so a read of 0xA misses; reset it during ALLOCATE
    cpu_req_addr  = 4'hA;
    cpu_req_rw    = 1'b0;
    cpu_req_valid = 1'b1;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("midalloc_reset_ready", int'(cache_ready), 1);
    check("midalloc_reset_dout", int'(cpu_req_dataout), 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(cache_ready), 1);

    run_req(4'hA, 8'h00, 1'b0, lat);
    $display("[TB] RD addr=0xa after reset lat=%0d dout=0x%0h", lat, cpu_req_dataout);
    check("post_reset_readA_latency", lat, 4);
    check("post_reset_readA_dout", int'(cpu_req_dataout), 8'hA5);

    // Memory is reinitialised by reset, so the earlier write-back of 0xC0 to 0xB is gone
    run_req(4'hB, 8'h00, 1'b0, lat);
    $display("[TB] RD addr=0xb after reset lat=%0d dout=0x%0h", lat, cpu_req_dataout);
    check("post_reset_readB_latency", lat, 4);
    check("post_reset_readB_dout", int'(cpu_req_dataout), 8'hB4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_32.md
REG_32 -- requirements
Module: reg_32

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous reset, asserted when 1 (name retained from codebase; polarity is active-high).
REQ-004 cpu_req_addr  input  4  CPU byte address; tag = addr[3:2], index = addr[1:0].
REQ-005 cpu_req_datain  input  8  CPU write data.
REQ-006 cpu_req_rw  input  1  0 = read, 1 = write.
REQ-007 cpu_req_valid  input  1  request strobe.
REQ-008 cpu_req_dataout  output  8  read data, registered.
REQ-009 cache_ready  output  1  high only in IDLE; controller accepts a request.

Function
REQ-010 The cache SHALL be direct-mapped: 4 lines, 1 byte each; per line valid, dirty, 2-bit tag, 8-bit data.
REQ-011 Policy SHALL be write-back, write-allocate.
REQ-012 The backing store SHALL be an internal 16x8 memory with fixed 2-cycle access latency (MEM_LAT = 2).
REQ-013 FSM states SHALL be IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE.
REQ-014 In IDLE, cpu_req_valid = 1 at a rising edge SHALL latch addr, datain and rw, and move to COMPARE_TAG; valid SHALL be ignored in all other states.
REQ-015 Hit condition: line valid and tag equal.
REQ-016 COMPARE_TAG, hit, read: cpu_req_dataout <= line data; go to IDLE.
REQ-017 COMPARE_TAG, hit, write: line data <= latched datain, dirty <= 1; go to IDLE; dataout SHALL be unchanged.
REQ-018 COMPARE_TAG, miss, victim clean or invalid: go to ALLOCATE.
REQ-019 COMPARE_TAG, miss, victim valid and dirty: go to WRITE_BACK.
REQ-020 WRITE_BACK SHALL last exactly MEM_LAT cycles, write the victim data to memory[{old tag, index}], then go to ALLOCATE.
REQ-021 ALLOCATE SHALL last exactly MEM_LAT cycles, then fill the line with memory[latched addr], set valid = 1, dirty = 0 and tag = new tag, and return to COMPARE_TAG; the request then completes as a hit.
REQ-022 Latency, measured as cycles with cache_ready low after the accepting edge: hit = 1; clean miss = 4; dirty miss = 6.
REQ-023 cpu_req_dataout SHALL hold its last value except on completion of a read.
REQ-024 Back-to-back operation: a request presented in the first IDLE cycle after completion SHALL be accepted.

Reset
REQ-025 Reset SHALL be effective at any time, including mid-WRITE_BACK or mid-ALLOCATE, and SHALL abort the operation with no partial line update.
REQ-026 Reset values: state = IDLE, cache_ready = 1, cpu_req_dataout = 0x00, all valid and dirty bits = 0, latency counter = 0.
REQ-027 Reset SHALL initialize the backing memory to mem[a] = {a, ~a}, e.g. mem[0xA] = 0xA5, mem[0xB] = 0xB4, mem[0x3] = 0x3C.

Structure
REQ-028 Shared package reg_32_pkg SHALL hold ADDR_W = 4, DATA_W = 8, TAG_W = 2, INDEX_W = 2, MEM_LAT = 2 and the FSM state enum.
REQ-029 The backing store SHALL be one sub-module, reg_32_mem, containing the 16x8 array, its reset init, the latency counter and the read/write ports; the FSM and tag/data arrays SHALL stay in reg_32.

Verification
REQ-030 Reset: after reset release -> cache_ready = 1, cpu_req_dataout = 0x00.
REQ-031 Read 0xA, first access -> cache_ready low 4 cycles, then cpu_req_dataout = 0xA5.
REQ-032 Read 0xA again -> cache_ready low 1 cycle, cpu_req_dataout = 0xA5.
REQ-033 Write 0xC0 to 0xB (miss) -> 4 cycles; line 3 dirty; then read 0xB -> 1 cycle, cpu_req_dataout = 0xC0.
REQ-034 Read 0x3 (conflicts with dirty line 3) -> 6 cycles, cpu_req_dataout = 0x3C; then read 0xB -> 4 cycles, cpu_req_dataout = 0xC0 (write-back verified).
REQ-035 Reset asserted during ALLOCATE of a read to 0xA -> immediate IDLE, cache_ready = 1; a following read of 0xA SHALL be a 4-cycle miss.
